id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage pipelined CPU, with built-in load-use hazard detection.
- Captures decoded operands, register indices and control from ID, and presents them to EX.
- Its ID_EX_rs1/ID_EX_rs2 outputs feed the forwarding unit directly.
- Generates the stall request that freezes the PC and the IF/ID register, inserts bubbles on stall or flush, and keeps saturating stall/flush event counters.

---
 rtl/id_ex_stage.sv | 128 ++++++++++++
 tb/tb_id_ex_stage.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the 5-stage CPU with built-in load-use hazard
// detection.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   IF_ID_*, rs*, rd,     decoded instruction from ID (operands, indices,
//   use_rs*, imm, ctrl    immediate, control bits)
//   flush                 EX-resolved redirect; the ID instruction is killed
//   stall                 combinational request to hold PC and IF/ID
//   ID_EX_*               registered copy of the instruction presented to EX
//   stall_cnt, flush_cnt  saturating event counters, cleared only by reset
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IF_ID_valid,
  input  logic [XLEN-1:0]  IF_ID_pc,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic             flush,
  output logic             stall,
  output logic             ID_EX_valid,
  output logic [XLEN-1:0]  ID_EX_pc,
  output logic [XLEN-1:0]  ID_EX_rs1_data,
  output logic [XLEN-1:0]  ID_EX_rs2_data,
  output logic [XLEN-1:0]  ID_EX_imm,
  output logic [4:0]       ID_EX_rs1,
  output logic [4:0]       ID_EX_rs2,
  output logic [4:0]       ID_EX_rd,
  output logic             ID_EX_mem_read,
  output logic             ID_EX_mem_write,
  output logic             ID_EX_reg_write,
  output logic             ID_EX_mem_to_reg,
  output logic             ID_EX_alu_src,
  output logic [1:0]       ID_EX_alu_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load_in_ex;
  logic hazard_rs1;
  logic hazard_rs2;
  logic bubble;

  // A load in EX whose destination is a real register; x0 never creates a
  // dependency because it always reads as zero.
  assign load_in_ex = ID_EX_valid & ID_EX_mem_read & (ID_EX_rd != 5'd0);
  assign hazard_rs1 = use_rs1 & (rs1 == ID_EX_rd);
  assign hazard_rs2 = use_rs2 & (rs2 == ID_EX_rd);

  // A flush kills the ID instruction anyway, so it suppresses the stall and
  // the cycle is accounted as a flush only.
  assign stall  = IF_ID_valid & ~flush & load_in_ex & (hazard_rs1 | hazard_rs2);
  assign bubble = flush | stall;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      // A bubble zeroes the indices too, so the forwarding unit never matches
      // against it, and zeroes the controls so it never writes or touches memory.
      ID_EX_valid      <= 1'b0;
      ID_EX_pc         <= '0;
      ID_EX_rs1_data   <= '0;
      ID_EX_rs2_data   <= '0;
      ID_EX_imm        <= '0;
      ID_EX_rs1        <= '0;
      ID_EX_rs2        <= '0;
      ID_EX_rd         <= '0;
      ID_EX_mem_read   <= 1'b0;
      ID_EX_mem_write  <= 1'b0;
      ID_EX_reg_write  <= 1'b0;
      ID_EX_mem_to_reg <= 1'b0;
      ID_EX_alu_src    <= 1'b0;
      ID_EX_alu_op     <= '0;
    end else begin
      ID_EX_valid      <= IF_ID_valid;
      ID_EX_pc         <= IF_ID_pc;
      ID_EX_rs1_data   <= rs1_data;
      ID_EX_rs2_data   <= rs2_data;
      ID_EX_imm        <= imm;
      ID_EX_rs1        <= rs1;
      ID_EX_rs2        <= rs2;
      ID_EX_rd         <= rd;
      // An invalid slot carries no side effects whatever the decoder produced.
      ID_EX_mem_read   <= mem_read   & IF_ID_valid;
      ID_EX_mem_write  <= mem_write  & IF_ID_valid;
      ID_EX_reg_write  <= reg_write  & IF_ID_valid;
      ID_EX_mem_to_reg <= mem_to_reg & IF_ID_valid;
      ID_EX_alu_src    <= alu_src    & IF_ID_valid;
      ID_EX_alu_op     <= alu_op & {2{IF_ID_valid}};
    end
  end

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. Expected ID/EX contents are pushed to a
// queue as each instruction is driven and popped after the capturing edge.
// The DUT is built with CNT_W=2 so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  d1;
    logic [XLEN-1:0]  d2;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] fcnt;
  } out_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_valid;
  logic [XLEN-1:0]  i_pc;
  logic [4:0]       i_rs1, i_rs2, i_rd;
  logic             i_use1, i_use2;
  logic [XLEN-1:0]  i_d1, i_d2, i_imm;
  logic             i_mr, i_mw, i_rw, i_m2r, i_as;
  logic [1:0]       i_aop;
  logic             i_flush;

  logic             stall;
  logic             o_valid;
  logic [XLEN-1:0]  o_pc, o_d1, o_d2, o_imm;
  logic [4:0]       o_rs1, o_rs2, o_rd;
  logic             o_mr, o_mw, o_rw, o_m2r, o_as;
  logic [1:0]       o_aop;
  logic [CNT_W-1:0] o_scnt, o_fcnt;

  out_t             exp_q[$];
  out_t             got;
  out_t             e;
  logic [CNT_W-1:0] exp_scnt;
  logic [CNT_W-1:0] exp_fcnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_ID_valid      (i_valid),
    .IF_ID_pc         (i_pc),
    .rs1              (i_rs1),
    .rs2              (i_rs2),
    .rd               (i_rd),
    .use_rs1          (i_use1),
    .use_rs2          (i_use2),
    .rs1_data         (i_d1),
    .rs2_data         (i_d2),
    .imm              (i_imm),
    .mem_read         (i_mr),
    .mem_write        (i_mw),
    .reg_write        (i_rw),
    .mem_to_reg       (i_m2r),
    .alu_src          (i_as),
    .alu_op           (i_aop),
    .flush            (i_flush),
    .stall            (stall),
    .ID_EX_valid      (o_valid),
    .ID_EX_pc         (o_pc),
    .ID_EX_rs1_data   (o_d1),
    .ID_EX_rs2_data   (o_d2),
    .ID_EX_imm        (o_imm),
    .ID_EX_rs1        (o_rs1),
    .ID_EX_rs2        (o_rs2),
    .ID_EX_rd         (o_rd),
    .ID_EX_mem_read   (o_mr),
    .ID_EX_mem_write  (o_mw),
    .ID_EX_reg_write  (o_rw),
    .ID_EX_mem_to_reg (o_m2r),
    .ID_EX_alu_src    (o_as),
    .ID_EX_alu_op     (o_aop),
    .stall_cnt        (o_scnt),
    .flush_cnt        (o_fcnt)
  );

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout: summary not reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t s;
    s = '{o_valid, o_pc, o_d1, o_d2, o_imm, o_rs1, o_rs2, o_rd,
          o_mr, o_mw, o_rw, o_m2r, o_as, o_aop, o_scnt, o_fcnt};
    return s;
  endfunction

  // Expected contents after a normal capture of the currently driven inputs.
  function automatic out_t cap_exp();
    out_t c;
    c = '{i_valid, i_pc, i_d1, i_d2, i_imm, i_rs1, i_rs2, i_rd,
          i_mr & i_valid, i_mw & i_valid, i_rw & i_valid, i_m2r & i_valid,
          i_as & i_valid, i_aop & {2{i_valid}}, exp_scnt, exp_fcnt};
    return c;
  endfunction

  function automatic out_t bubble_exp();
    out_t b;
    b = '0;
    b.scnt = exp_scnt;
    b.fcnt = exp_fcnt;
    return b;
  endfunction

  // ctrl = {mem_read, mem_write, reg_write, mem_to_reg, alu_src}
  task automatic set_instr(input logic v, input logic [XLEN-1:0] pc,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                           input logic u1, input logic u2,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] im, input logic [4:0] ctrl,
                           input logic [1:0] aop);
    i_valid = v;  i_pc = pc;  i_rs1 = r1;  i_rs2 = r2;  i_rd = d;
    i_use1 = u1;  i_use2 = u2;  i_d1 = a;  i_d2 = b;  i_imm = im;
    {i_mr, i_mw, i_rw, i_m2r, i_as} = ctrl;
    i_aop = aop;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_flush = 1'b1;
    set_instr(1'b1, 32'hDEAD, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 5'b11111, 2'b11);
    exp_scnt = '0;
    exp_fcnt = '0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(bubble_exp());
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got=%h required=%h", k, got, e);
      end
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got=%b required=0", stall);
    end
    reset = 1'b0;
    i_flush = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_passthrough();
    set_instr(1'b1, 32'h100, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 32'hAA, 32'hBB, 32'h0, 5'b00100, 2'b00);
    #1; n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_stall got=%b required=0", stall);
    end
    exp_q.push_back(cap_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL passthrough got=%h required=%h", got, e);
    end
    $display("test_passthrough pc=%h rd=%0d", got.pc, got.rd);
  endtask

  task automatic test_load_use();
    // Load x7
    set_instr(1'b1, 32'h104, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'h11, 32'h22, 32'h8, 5'b10111, 2'b00);
    #1; n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_load_stall got=%b required=0", stall);
    end
    exp_q.push_back(cap_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL lu_load_capture got=%h required=%h", got, e);
    end
    // Dependent consumer of x7
    set_instr(1'b1, 32'h108, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 32'h33, 32'h44, 32'h0, 5'b00100, 2'b10);
    #1; n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall got=%b required=1", stall);
    end
    exp_scnt = exp_scnt + 1'b1;
    exp_q.push_back(bubble_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL lu_bubble got=%h required=%h", got, e);
    end
    // Held instruction must now go through, with no second stall.
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall_one_cycle got=%b required=0", stall);
    end
    exp_q.push_back(cap_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL lu_dependent got=%h required=%h", got, e);
    end
    $display("test_load_use rs1=%0d stall_cnt=%0d", got.rs1, got.scnt);
  endtask

  task automatic test_no_false_stall();
    // {producer rd, producer ctrl, consumer rs1, rs2, use1, use2}
    logic [4:0] prd  [3] = '{5'd0, 5'd7, 5'd7};
    logic [4:0] pctl [3] = '{5'b10111, 5'b10111, 5'b00100};
    logic [4:0] crs1 [3] = '{5'd0, 5'd1, 5'd7};
    logic [4:0] crs2 [3] = '{5'd0, 5'd7, 5'd2};
    logic       cu1  [3] = '{1'b1, 1'b1, 1'b1};
    logic       cu2  [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      set_instr(1'b1, 32'h300 + 32'(k * 8), 5'd1, 5'd2, prd[k], 1'b1, 1'b0,
                32'h5, 32'h6, 32'h7, pctl[k], 2'b00);
      exp_q.push_back(cap_exp());
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL nfs_producer[%0d] got=%h required=%h", k, got, e);
      end
      set_instr(1'b1, 32'h304 + 32'(k * 8), crs1[k], crs2[k], 5'd9, cu1[k], cu2[k],
                32'h9, 32'hA, 32'hB, 5'b00101, 2'b01);
      #1; n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL nfs_stall[%0d] got=%b required=0", k, stall);
      end
      exp_q.push_back(cap_exp());
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL nfs_consumer[%0d] got=%h required=%h", k, got, e);
      end
    end
    // Invalid ID slot behind a load x7 that would otherwise hazard.
    set_instr(1'b1, 32'h320, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10111, 2'b00);
    @(posedge clk); #1;
    set_instr(1'b0, 32'h324, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 5'b11111, 2'b11);
    #1; n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_stall got=%b required=0", stall);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({o_valid, o_mr, o_mw, o_rw, o_m2r, o_as, o_aop} !== 8'h00) begin
      n_fail++;
      $display("FAIL invalid_ctrl got=%b required=00000000",
               {o_valid, o_mr, o_mw, o_rw, o_m2r, o_as, o_aop});
    end
    $display("test_no_false_stall done");
  endtask

  task automatic test_flush();
    set_instr(1'b1, 32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 5'b10111, 2'b00);
    exp_q.push_back(cap_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL flush_load got=%h required=%h", got, e);
    end
    set_instr(1'b1, 32'h404, 5'd1, 5'd9, 5'd10, 1'b0, 1'b1, 32'h1, 32'h2, 32'h0, 5'b01000, 2'b00);
    i_flush = 1'b1;
    #1; n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall got=%b required=0", stall);
    end
    exp_fcnt = exp_fcnt + 1'b1;
    exp_q.push_back(bubble_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL flush_bubble got=%h required=%h", got, e);
    end
    i_flush = 1'b0;
    $display("test_flush flush_cnt=%0d stall_cnt=%0d", got.fcnt, got.scnt);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      set_instr(1'b1, 32'h500 + 32'(k * 4), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, {1'b0, 4'($urandom_range(0, 15))},
                2'($urandom_range(0, 3)));
      #1; n_checks++;
      if (stall !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_stall[%0d] got=%b required=0", k, stall);
      end
      exp_q.push_back(cap_exp());
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d] got=%h required=%h", k, got, e);
      end
      $display("b2b[%0d] pc=%h rd=%0d", k, got.pc, got.rd);
    end
  endtask

  task automatic test_saturation();
    int sat [5] = '{1, 2, 3, 3, 3};
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_scnt = '0;
    exp_fcnt = '0;
    i_flush = 1'b1;
    set_instr(1'b1, 32'h600, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 5'b00100, 2'b00);
    for (int k = 0; k < 5; k++) begin
      exp_fcnt = CNT_W'(sat[k]);
      exp_q.push_back(bubble_exp());
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL sat[%0d] got=%h required=%h", k, got, e);
      end
      $display("sat[%0d] flush_cnt=%0d", k, got.fcnt);
    end
    i_flush = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (o_fcnt !== '0) begin
      n_fail++;
      $display("FAIL sat_reset got=%0d required=0", o_fcnt);
    end
    exp_fcnt = '0;
  endtask

  task automatic test_reset_mid_stall();
    set_instr(1'b1, 32'h700, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'b10111, 2'b00);
    @(posedge clk); #1;
    set_instr(1'b1, 32'h704, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2, 32'h3, 5'b00100, 2'b00);
    #1; n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rms_stall_before got=%b required=1", stall);
    end
    reset = 1'b1;
    exp_scnt = '0;
    exp_fcnt = '0;
    exp_q.push_back(bubble_exp());
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rms_state got=%h required=%h", got, e);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rms_stall_after got=%b required=0", stall);
    end
    reset = 1'b0;
    $display("test_reset_mid_stall stall_cnt=%0d", got.scnt);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
